// File: rtl/axi4_rd_arbiter.sv
// rtl/axi4_rd_arbiter.sv - two-master round-robin arbiter for one AXI4 slave read path
// One burst is in flight at a time; R beats are steered to the granted master until RLAST.
module axi4_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    localparam int AR_W  = ID_W + ADDR_W + 13,
    localparam int R_W   = ID_W + DATA_W + 3
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [1:0]        m_arvalid,
    output logic [1:0]        m_arready,
    input  logic [2*AR_W-1:0] m_ar,
    output logic [1:0]        m_rvalid,
    input  logic [1:0]        m_rready,
    output logic [R_W-1:0]    m_r,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [AR_W-1:0]   s_ar,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [R_W-1:0]    s_r,
    output logic              len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state, state_nxt;
    logic            grant;
    logic            prio;
    logic            sel;
    logic            req_any;
    logic [AR_W-1:0] sel_ar;
    logic [8:0]      beat_cnt;
    logic [7:0]      len_target;
    logic            err_seen;
    logic            r_hs;
    logic            r_last;
    logic            at_target;

    assign req_any   = |m_arvalid;
    assign sel       = (&m_arvalid) ? prio : m_arvalid[1];
    assign sel_ar    = sel ? m_ar[2*AR_W-1:AR_W] : m_ar[AR_W-1:0];
    assign m_r       = s_r;
    assign r_last    = s_r[0];
    assign at_target = (beat_cnt == {1'b0, len_target});

    always_comb begin
        state_nxt = state;
        m_arready = 2'b00;
        m_rvalid  = 2'b00;
        s_rready  = 1'b0;
        r_hs      = 1'b0;
        len_err   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    m_arready = sel ? 2'b10 : 2'b01;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (s_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                m_rvalid = grant ? {s_rvalid, 1'b0} : {1'b0, s_rvalid};
                s_rready = m_rready[grant];
                r_hs     = s_rvalid && s_rready;
                if (r_hs) begin
                    // Either a short burst (RLAST early) or the expected last beat without RLAST;
                    // err_seen keeps an overrun from reporting on every later beat.
                    len_err = !err_seen && (r_last ? !at_target : at_target);
                    if (r_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            s_arvalid  <= 1'b0;
            s_ar       <= '0;
            grant      <= 1'b0;
            prio       <= 1'b0;
            beat_cnt   <= '0;
            len_target <= '0;
            err_seen   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        s_ar       <= sel_ar;
                        s_arvalid  <= 1'b1;
                        grant      <= sel;
                        beat_cnt   <= '0;
                        len_target <= sel_ar[12:5];
                        err_seen   <= 1'b0;
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        s_arvalid <= 1'b0;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        if (beat_cnt != 9'h1FF) begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                        if (len_err) begin
                            err_seen <= 1'b1;
                        end
                        if (r_last) begin
                            prio <= ~grant;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// tb/tb_axi4_rd_arbiter.sv - randomized self-checking bench for axi4_rd_arbiter
// Expected grants, payloads and len_err come from a per-burst reference model held here.
module tb_axi4_rd_arbiter;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int AR_W   = ID_W + ADDR_W + 13;
    localparam int R_W    = ID_W + DATA_W + 3;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic [1:0]        m_arvalid = 2'b00;
    logic [1:0]        m_arready;
    logic [2*AR_W-1:0] m_ar = '0;
    logic [1:0]        m_rvalid;
    logic [1:0]        m_rready = 2'b00;
    logic [R_W-1:0]    m_r;
    logic              s_arvalid;
    logic              s_arready = 1'b0;
    logic [AR_W-1:0]   s_ar;
    logic              s_rvalid = 1'b0;
    logic              s_rready;
    logic [R_W-1:0]    s_r = '0;
    logic              len_err;

    int total = 0;
    int bad   = 0;
    logic mprio = 1'b0;

    axi4_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar(m_ar),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r(m_r),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
        .len_err(len_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AR_W-1:0] mk_ar(input logic [ID_W-1:0] id,
                                             input logic [ADDR_W-1:0] addr,
                                             input logic [7:0] len);
        return {id, addr, len, 3'd3, 2'd1};
    endfunction

    // One complete burst; nbeats = ARLEN+1+delta (min 1); abort_beat >= 0 pulls reset during that beat.
    task automatic burst(input logic [1:0] req, input logic [7:0] len0, input logic [7:0] len1,
                         input int delta, input int ar_delay, input int abort_beat);
        logic            g;
        logic [AR_W-1:0] a0, a1, exp_ar;
        logic [R_W-1:0]  rd;
        int              tgt, nbeats, k, budget;
        bit              reported, last, hs, exp_err;
        a0 = mk_ar(4'($urandom), 32'($urandom), len0);
        a1 = mk_ar(4'($urandom), 32'($urandom), len1);
        g = (req == 2'b11) ? mprio : req[1];
        exp_ar = g ? a1 : a0;
        tgt = int'(g ? len1 : len0) + 1;
        nbeats = tgt + delta;
        if (nbeats < 1) nbeats = 1;
        m_ar = {a1, a0};
        m_arvalid = req;
        s_arready = 1'b0;
        s_rvalid = 1'b0;
        @(negedge ACLK);
        chk("ar_grant", m_arready, g ? 2'b10 : 2'b01);
        chk("sarv_lat", s_arvalid, 1'b0);
        @(posedge ACLK); #1;
        m_arvalid = req & ~(g ? 2'b10 : 2'b01);
        for (int d = 0; d <= ar_delay; d++) begin
            s_arready = (d == ar_delay);
            @(negedge ACLK);
            chk("s_arvalid", s_arvalid, 1'b1);
            chk("s_ar", s_ar, exp_ar);
            chk("ar_busy", m_arready, 2'b00);
            @(posedge ACLK); #1;
        end
        s_arready = 1'b0;
        k = 0;
        budget = 0;
        reported = 0;
        while (k < nbeats && budget < 3000) begin
            last = (k == nbeats - 1);
            s_rvalid = ($urandom_range(3) != 0);
            rd = R_W'({$urandom, $urandom, $urandom});
            rd[0] = last;
            s_r = rd;
            m_rready = 2'($urandom);
            if (k == abort_beat) begin
                s_rvalid = 1'b1;
                m_rready = 2'b11;
                #1;
                ARESETn = 1'b0;
                #1;
                chk("rst_sarv", s_arvalid, 1'b0);
                chk("rst_mrv", m_rvalid, 2'b00);
                chk("rst_srr", s_rready, 1'b0);
                @(posedge ACLK);
                @(posedge ACLK); #1;
                ARESETn = 1'b1;
                s_rvalid = 1'b0;
                m_rready = 2'b00;
                m_arvalid = 2'b00;
                mprio = 1'b0;
                return;
            end
            @(negedge ACLK);
            hs = s_rvalid && m_rready[g];
            exp_err = hs && !reported && (last ? (k + 1 != tgt) : (k + 1 == tgt));
            chk("m_rvalid", m_rvalid, g ? {s_rvalid, 1'b0} : {1'b0, s_rvalid});
            chk("s_rready", s_rready, m_rready[g]);
            chk("m_r", m_r, rd);
            chk("len_err", len_err, exp_err);
            chk("ar_bubble", m_arready, 2'b00);
            if (exp_err) reported = 1;
            if (hs) k++;
            @(posedge ACLK); #1;
            budget++;
        end
        chk("beat_budget", budget < 3000, 1'b1);
        s_rvalid = 1'b0;
        m_rready = 2'b00;
        mprio = ~g;
    endtask

    task automatic idle_check();
        m_arvalid = 2'b00;
        @(negedge ACLK);
        chk("idle_arready", m_arready, 2'b00);
        chk("idle_sarv", s_arvalid, 1'b0);
        @(posedge ACLK); #1;
    endtask

    initial begin
        logic [1:0] rq;
        int dl;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rst_arready", m_arready, 2'b00);
        chk("rst_s_arvalid", s_arvalid, 1'b0);
        chk("rst_s_ar", s_ar, '0);
        chk("rst_m_rvalid", m_rvalid, 2'b00);
        chk("rst_s_rready", s_rready, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        @(posedge ACLK); #1;

        burst(2'b01, 8'd3, 8'd0, 0, 0, -1);
        idle_check();
        repeat (4) burst(2'b11, 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), 0, $urandom_range(0, 2), -1);
        burst(2'b10, 8'd0, 8'd1, 0, 5, -1);
        burst(2'b01, 8'd3, 8'd0, -2, 1, -1);
        burst(2'b01, 8'd1, 8'd0, 2, 0, -1);
        idle_check();
        for (int i = 0; i < 14; i++) begin
            rq = 2'($urandom_range(1, 3));
            dl = ($urandom_range(3) == 0) ? (int'($urandom_range(0, 2)) - 1) : 0;
            burst(rq, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), dl, $urandom_range(0, 3), -1);
            if ($urandom_range(1) == 0) idle_check();
        end
        burst(2'b01, 8'd255, 8'd0, 0, 0, -1);
        burst(2'b10, 8'd0, 8'd7, 0, 0, 1);
        idle_check();
        burst(2'b10, 8'd0, 8'd2, 0, 1, -1);
        burst(2'b11, 8'd1, 8'd1, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_rd_arbiter.md
Name: axi4_rd_arbiter

Overview:
- Shares one AXI4 slave read path (AR + R channels) between two masters, one burst at a time.
- Round-robin arbitration on AR; routes R beats back to the granted master until the RLAST handshake completes.
- Counts beats against ARLEN and flags length mismatches.
- Sits between two master read ports and a single slave on the ACLK domain.

Parameters:
ID_W, 4, ARID/RID width
ADDR_W, 32, ARADDR width
DATA_W, 64, RDATA width
(derived, not overridable) AR_W = ID_W+ADDR_W+13, packed {ARID,ARADDR,ARLEN[7:0],ARSIZE[2:0],ARBURST[1:0]}, MSB first
(derived, not overridable) R_W = ID_W+DATA_W+3, packed {RID,RDATA,RRESP[1:0],RLAST}, RLAST at bit 0

Ports:
ACLK  in  1  clock, the single clock; all logic on rising edge
ARESETn  in  1  reset, asynchronous, active-low
m_arvalid  in  2  per-master AR valid (bit i = master i)
m_arready  out  2  per-master AR ready
m_ar  in  2*AR_W  per-master AR payload, master i at [i*AR_W +: AR_W]
m_rvalid  out  2  per-master R valid
m_rready  in  2  per-master R ready
m_r  out  R_W  R payload, broadcast to both masters
s_arvalid  out  1  slave AR valid
s_arready  in  1  slave AR ready
s_ar  out  AR_W  slave AR payload, registered
s_rvalid  in  1  slave R valid
s_rready  out  1  slave R ready
s_r  in  R_W  slave R payload
len_err  out  1  one-cycle pulse on beat-count mismatch

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, s_arvalid=0, s_ar=0, grant=0, prio=0, beat_cnt=0, len_err=0. m_arready, m_rvalid and s_rready are 0 while in IDLE after reset.
- Reset asserted mid-burst abandons the burst immediately. No outstanding tracking survives reset.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - m_arready is combinational. m_arready[g]=1 only for the selected requester g.
  - Selection: if both masters are valid, g=prio. Otherwise g is the single valid master.
  - On selection: s_ar <= m_ar[g], s_arvalid <= 1, grant <= g, beat_cnt <= 0, len_target <= ARLEN of the request. Next state ADDR.
  - AR latency is 1 cycle: the master handshake happens in cycle N, s_arvalid is high in N+1.
- ADDR:
  - s_arvalid=1 and s_ar stay stable until s_arready=1.
  - On handshake: s_arvalid <= 0, next state DATA.
  - m_arready=2'b00.
- DATA:
  - m_rvalid[grant]=s_rvalid; the other bit is 0. s_rready=m_rready[grant]. m_r=s_r (combinational pass-through).
  - A handshake is s_rvalid&&s_rready. Each handshake increments beat_cnt (9-bit).
  - On a handshake with RLAST=1: next state IDLE, prio <= ~grant.
  - In that same cycle, len_err pulses for one cycle if beat_cnt != len_target, i.e. fewer or more than ARLEN+1 beats.
  - If beat_cnt reaches len_target and RLAST=0, len_err pulses on that beat. The FSM keeps forwarding until RLAST.
  - m_arready=2'b00.
- A new request arriving in the same cycle as the final RLAST handshake is not granted that cycle. It is granted in the following IDLE cycle (one-cycle bubble, required).
- No combinational path from m_arvalid to s_arvalid. s_r to m_r and m_rready to s_rready are combinational.
- A master dropping arvalid in IDLE before a handshake is legal; arbitration re-evaluates each cycle.
- ARLEN=255 gives beat_cnt a range of 0..255, with no wrap before RLAST. An overrun past 255 saturates the counter, and len_err fires once.

Test Plan:
- Single request: m0 AR ARID=3, ARADDR=0x1000, ARLEN=3; slave returns 4 beats with RLAST on beat 4 -> s_arvalid rises 1 cycle after m_arready[0]; m_rvalid[0] on each beat; m_rvalid[1]=0 throughout; len_err=0; FSM back in IDLE.
- Contention: both masters hold arvalid from reset -> m0 granted first (prio=0); after its RLAST, m1 granted after a one-cycle bubble; next contention goes to m0. This verifies round-robin alternation over 4 bursts.
- Backpressure: s_arready is low for 5 cycles, then m_rready[1] toggles 1/0 during a 2-beat burst (ARLEN=1) -> s_ar stays stable for all 5 cycles; s_rready mirrors m_rready[1]; data and ordering are preserved.
- Length errors: ARLEN=3 with RLAST on beat 2 -> len_err pulses on beat 2 and the FSM goes to IDLE. ARLEN=1 with RLAST on beat 4 -> len_err pulses once on beat 2 and the FSM stays in DATA until beat 4.
- Reset mid-burst: drop ARESETn during beat 2 of an ARLEN=7 burst -> s_arvalid, m_rvalid and s_rready go to 0 asynchronously; after release the FSM is in IDLE with prio=0, and a new m1 request is granted normally.
